// File: rtl/spi_frame_rx.sv
// spi_frame_rx: oversampled DIN/SCLK/SYN frame receiver with a one-deep valid/ready output word.
// Optional macro SPI_RX_TIMEOUT_EN adds an SCLK inactivity timeout that aborts a stalled frame.
module spi_frame_rx #(
    parameter int DATA_W         = 32,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              DIN,
    input  logic              SCLK,
    input  logic              SYN,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_err,
    output logic              rx_ovf,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W + 2);

    localparam logic [1:0] ST_RESYNC = 2'd0;
    localparam logic [1:0] ST_IDLE   = 2'd1;
    localparam logic [1:0] ST_SHIFT  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DATA_W + 1);

    logic [SYNC_STAGES-1:0] din_sync_q;
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] syn_sync_q;
    logic                   din_s;
    logic                   sclk_s;
    logic                   syn_s;

    logic sclk_p_q;
    logic syn_p_q;
    logic din_q;
    logic sclk_fall_q;
    logic syn_fall_q;
    logic syn_rise_q;

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [DATA_W-1:0] shreg_q;
    logic [DATA_W-1:0] shreg_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;
    logic              valid_q;
    logic              valid_d;
    logic              err_q;
    logic              err_d;
    logic              ovf_q;
    logic              ovf_d;
    logic              tmo_hit;

    // Input synchronizers; SYN resets low so the link stays ignored until it is really seen high
    always_ff @(posedge clk) begin
        if (reset) begin
            din_sync_q  <= '0;
            sclk_sync_q <= '1;
            syn_sync_q  <= '0;
        end else begin
            din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], DIN};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
            syn_sync_q  <= {syn_sync_q[SYNC_STAGES-2:0], SYN};
        end
    end

    assign din_s  = din_sync_q[SYNC_STAGES-1];
    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign syn_s  = syn_sync_q[SYNC_STAGES-1];

    // Registered edge pulses; DIN is delayed alongside so it lines up with the SCLK fall pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_p_q    <= 1'b1;
            syn_p_q     <= 1'b0;
            din_q       <= 1'b0;
            sclk_fall_q <= 1'b0;
            syn_fall_q  <= 1'b0;
            syn_rise_q  <= 1'b0;
        end else begin
            sclk_p_q    <= sclk_s;
            syn_p_q     <= syn_s;
            din_q       <= din_s;
            sclk_fall_q <= sclk_p_q & ~sclk_s;
            syn_fall_q  <= syn_p_q & ~syn_s;
            syn_rise_q  <= ~syn_p_q & syn_s;
        end
    end

`ifdef SPI_RX_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_q;
    logic [TMO_W-1:0] tmo_d;

    // Cycles since entering SHIFT or since the last SCLK fall
    always_comb begin
        tmo_d = tmo_q + TMO_W'(1);
        if (state_q != ST_SHIFT || sclk_fall_q) begin
            tmo_d = '0;
        end
    end

    assign tmo_hit = (state_q == ST_SHIFT) && !sclk_fall_q &&
                     (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    // Timeout counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES;
    assign tmo_hit    = 1'b0;
`endif

    // Frame state machine, bit shifting, frame evaluation and output handshake
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        valid_d = valid_q;
        err_d   = 1'b0;
        ovf_d   = 1'b0;

        if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            ST_RESYNC: begin
                cnt_d   = '0;
                shreg_d = '0;
                if (syn_p_q) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                cnt_d   = '0;
                shreg_d = '0;
                if (syn_fall_q) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (syn_rise_q) begin
                    // An SCLK fall in this same cycle is deliberately not counted
                    state_d = ST_IDLE;
                    if (cnt_q != CNT_FULL) begin
                        err_d = 1'b1;
                    end else if (!valid_q || rx_ready) begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = ST_RESYNC;
                end else if (sclk_fall_q) begin
                    if (cnt_q < CNT_FULL) begin
                        shreg_d = {shreg_q[DATA_W-2:0], din_q};
                    end
                    if (cnt_q != CNT_SAT) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_RESYNC;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RESYNC;
            cnt_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
        end
    end

    assign rx_data  = data_q;
    assign rx_valid = valid_q;
    assign rx_err   = err_q;
    assign rx_ovf   = ovf_q;
    assign busy     = (state_q == ST_SHIFT);

endmodule

// File: doc/spi_frame_rx.md
# spi_frame_rx

Serial frame receiver for the three-wire DIN/SCLK/SYN link driven by the team's 32-bit DAC-style writer. It oversamples the link on the local `clk`, shifts DIN in MSB-first on each SCLK falling edge while SYN is low, and validates the bit count when SYN rises. Good frames are presented as a parallel word through a one-deep valid/ready output register. It sits on the loop-back/readback side of the DAC control path for self-test and inter-board links.

## Interface
- `DATA_W`, 32, frame length in bits; also the output width.
- `SYNC_STAGES`, 2, flip-flops in each input synchronizer (minimum 2).
- `TIMEOUT_CYCLES`, 1024, `clk` cycles without an SCLK falling edge before a frame is aborted. Used only with `SPI_RX_TIMEOUT_EN`.

- `clk`  input  1  system clock; at least 4× the SCLK rate.
- `reset`  input  1  synchronous, active-high reset.
- `DIN`  input  1  serial data, asynchronous to `clk`.
- `SCLK`  input  1  serial clock, idle high, asynchronous to `clk`.
- `SYN`  input  1  frame select, active low, asynchronous to `clk`.
- `rx_data`  output  DATA_W  received word; valid while `rx_valid`=1.
- `rx_valid`  output  1  word available.
- `rx_ready`  input  1  consumer accepts the word when `rx_valid`=1.
- `rx_err`  output  1  one-cycle pulse: frame discarded because of a bad bit count or a timeout.
- `rx_ovf`  output  1  one-cycle pulse: a good frame was dropped because the output register was full.
- `busy`  output  1  high while in SHIFT.

## Operation
- DIN, SCLK and SYN each pass through a `SYNC_STAGES` synchronizer. One further register on SCLK and SYN provides edge detection. The synchronized DIN is aligned with the synchronized SCLK.
- State machine:
  - **RESYNC**: entered on reset and after a timeout. Moves to IDLE when the synchronized SYN=1.
  - **IDLE**: moves to SHIFT on a synchronized SYN falling edge. Clears the bit counter and shift register.
  - **SHIFT**: on each SCLK falling edge, `shreg <= {shreg[DATA_W-2:0], din_s}`.
    - The bit counter increments and saturates at `DATA_W+1`.
    - Edges beyond `DATA_W` do not shift.
    - On a synchronized SYN rising edge, the FSM goes to IDLE and the frame is evaluated.
- Frame evaluation, performed on the SYN rising-edge cycle:
  - If count ≠ `DATA_W`, pulse `rx_err` and discard the frame.
  - If count = `DATA_W` and the output register is free, load `rx_data <= shreg` and set `rx_valid`=1.
  - If count = `DATA_W`, `rx_valid`=1 and `rx_ready`=0, pulse `rx_ovf`. The old word is kept and the new one is dropped.
  - If the output register is being accepted in the same cycle (`rx_valid`&`rx_ready`), the new word loads and `rx_valid` stays 1. No overflow is flagged.
- A SCLK falling edge and a SYN rising edge in the same synchronized cycle: the edge is not counted.
- Handshake: the transfer occurs on `rx_valid`&`rx_ready`, after which `rx_valid` clears. `rx_data` is held stable while `rx_valid`=1.
- SCLK edges while SYN is high are ignored.

## Timing
- Reset values: `rx_data`=0, `rx_valid`=0, `rx_err`=0, `rx_ovf`=0, `busy`=0. The state is RESYNC.
- Reset mid-frame: the partial frame is lost. The block ignores the link until SYN is seen high.
- Latency: `rx_valid`, `rx_err` and `rx_ovf` assert `SYNC_STAGES+2` `clk` cycles after the SYN rising edge reaches the pin (synchronizer, edge register, output register).
- `busy` rises `SYNC_STAGES+2` cycles after the SYN falling edge at the pin.
- SCLK high and low phases must each last at least 2 `clk` cycles. DIN must be stable from SCLK high through the falling edge.
- Back-to-back frames need SYN high for at least 2 `clk` cycles.

## Configuration
- `SPI_RX_TIMEOUT_EN` defined:
  - In SHIFT, a counter tracks `clk` cycles since the last SCLK falling edge, or since entering SHIFT.
  - The counter reaches `TIMEOUT_CYCLES` → pulse `rx_err`, discard the frame, go to RESYNC.
- `SPI_RX_TIMEOUT_EN` undefined: no counter is built. SHIFT waits indefinitely for SYN to rise, and `TIMEOUT_CYCLES` is ignored.

## Test plan
- Good frame: frame 32'h0A5A_C3F1, MSB first, SCLK = `clk`/8, `rx_ready`=1 → one `rx_valid` cycle with `rx_data`=32'h0A5A_C3F1, `rx_err`=0.
- Short and long frames: 31 edges, then 33 edges → `rx_err` pulses once per frame, `rx_valid` stays 0.
- Backpressure: two good frames 32'h1111_1111 then 32'h2222_2222 with `rx_ready`=0 → `rx_ovf` pulses once. Raising `rx_ready` then yields `rx_data`=32'h1111_1111.
- Simultaneous: `rx_ready` rises in the same cycle the second frame completes → first word accepted, second word loaded, no `rx_ovf`.
- Reset mid-frame: assert `reset` after 10 bits, release while SYN is still low, finish the frame → no `rx_valid` and no `rx_err`. The next full frame is received correctly.
- Timeout (macro defined, `TIMEOUT_CYCLES`=64): stop SCLK after 5 bits with SYN low → `rx_err` 64 cycles after the last edge. A following good frame is received once SYN has been high.
